// File: rtl/core_inst_seq.sv
// Purpose : drives core's 34-bit inst bus through one full tile pass (weight fetch/load, activation fetch/execute, OFIFO drain to pmem).
// Latency : first pass inst appears the cycle after start is sampled; inst/busy/done are all registered.
// Backpr. : drain stalls (idle inst, index held) while ofifo_valid is low; start is ignored while a pass is running.
//
// Ports: clk/reset (async active-low); start pulse with w_base/x_base/p_base/num_x/acc_en captured on the start cycle;
//        ofifo_valid from core; inst bus, busy level and one-cycle done pulse out.
// Assumes row, col and gap_cycles are all >= 1.
module core_inst_seq #(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int gap_cycles = 16,
    parameter int aw         = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] w_base,
    input  logic [aw-1:0] x_base,
    input  logic [aw-1:0] p_base,
    input  logic [aw-1:0] num_x,
    input  logic          acc_en,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          busy,
    output logic          done
);

    localparam int          cw        = 16;
    localparam logic [33:0] IDLE_INST = 34'h1800C0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WRD, S_WLD, S_WGAP, S_XRD, S_XEX, S_DRAIN, S_ORD0, S_ORD1, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [cw-1:0] cnt, cnt_n, cnt_inc;
    logic [aw-1:0] idx, idx_n, idx_inc;
    // ORD0 is entered before we know whether the OFIFO read can go out; issued
    // records that ofifo_valid was seen so the read inst is presented this cycle.
    logic          issued, issued_n;
    logic [aw-1:0] wb_q, xb_q, pb_q, nx_q, wb_n, xb_n, pb_n, nx_n;
    logic          acc_q, acc_n;
    logic [33:0]   inst_n;
    logic          busy_n, done_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            issued <= 1'b0;
            wb_q   <= '0;
            xb_q   <= '0;
            pb_q   <= '0;
            nx_q   <= '0;
            acc_q  <= 1'b0;
            inst   <= IDLE_INST;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            issued <= issued_n;
            wb_q   <= wb_n;
            xb_q   <= xb_n;
            pb_q   <= pb_n;
            nx_q   <= nx_n;
            acc_q  <= acc_n;
            inst   <= inst_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        issued_n = issued;
        wb_n     = wb_q;
        xb_n     = xb_q;
        pb_n     = pb_q;
        nx_n     = nx_q;
        acc_n    = acc_q;
        cnt_inc  = cnt + cw'(1);
        idx_inc  = idx + aw'(1);
        inst_n   = IDLE_INST;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    wb_n     = w_base;
                    xb_n     = x_base;
                    pb_n     = p_base;
                    nx_n     = num_x;
                    acc_n    = acc_en;
                    cnt_n    = '0;
                    idx_n    = '0;
                    issued_n = 1'b0;
                    state_n  = (num_x == '0) ? S_DONE : S_WRD;
                end
            end
            S_WRD: begin
                cnt_n = cnt_inc;
                if (cnt_inc == cw'(row)) begin
                    state_n = S_WLD;
                    cnt_n   = '0;
                end
            end
            S_WLD: begin
                cnt_n = cnt_inc;
                if (cnt_inc == cw'(col)) begin
                    state_n = S_WGAP;
                    cnt_n   = '0;
                end
            end
            S_WGAP: begin
                cnt_n = cnt_inc;
                if (cnt_inc == cw'(gap_cycles)) begin
                    state_n = S_XRD;
                    cnt_n   = '0;
                end
            end
            S_XRD: begin
                cnt_n = cnt_inc;
                if (cnt_inc == cw'(nx_q)) begin
                    state_n = S_XEX;
                    cnt_n   = '0;
                end
            end
            S_XEX: begin
                cnt_n = cnt_inc;
                if (cnt_inc == cw'(nx_q)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    state_n  = S_ORD0;
                    idx_n    = '0;
                    issued_n = 1'b1;
                end
            end
            S_ORD0: begin
                if (issued) begin
                    state_n = S_ORD1;
                end else if (ofifo_valid) begin
                    issued_n = 1'b1;
                end
            end
            S_ORD1: begin
                idx_n = idx_inc;
                if (idx_inc == nx_q) begin
                    state_n = S_DONE;
                end else begin
                    state_n  = S_ORD0;
                    issued_n = ofifo_valid;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Outputs are computed from the next state so they leave a flop.
        case (state_n)
            S_WRD: begin
                inst_n[19]   = 1'b0;
                inst_n[17:7] = wb_n + aw'(cnt_n);
            end
            S_WLD: begin
                inst_n[3] = 1'b1;
                inst_n[0] = 1'b1;
            end
            S_XRD: begin
                inst_n[19]   = 1'b0;
                inst_n[17:7] = xb_n + aw'(cnt_n);
            end
            S_XEX: begin
                inst_n[3] = 1'b1;
                inst_n[1] = 1'b1;
            end
            S_ORD0: begin
                if (issued_n) begin
                    inst_n[6]  = 1'b1;
                    inst_n[33] = acc_n;
                    if (acc_n) begin
                        inst_n[32]    = 1'b0;
                        inst_n[30:20] = pb_n + idx_n;
                    end
                end
            end
            S_ORD1: begin
                inst_n[33]    = acc_n;
                inst_n[32]    = 1'b0;
                inst_n[31]    = 1'b0;
                inst_n[30:20] = pb_n + idx_n;
            end
            default: inst_n = IDLE_INST;
        endcase

        // L0 write follows the xmem read presented in the current cycle, covering the SRAM read latency.
        inst_n[2] = ~inst[19] & inst[18];
        busy_n    = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n    = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_core_inst_seq.sv
module tb_core_inst_seq;
    localparam int          ROW  = 8;
    localparam int          COL  = 8;
    localparam int          GAP  = 16;
    localparam int          MAXC = 512;
    localparam logic [33:0] IDLE = 34'h1800C0000;

    logic        clk = 1'b0;
    logic        reset, start, acc_en, ofifo_valid;
    logic [10:0] w_base, x_base, p_base, num_x;
    logic [33:0] inst;
    logic        busy, done;

    always #5 clk = ~clk;

    core_inst_seq #(.row(ROW), .col(COL), .gap_cycles(GAP), .aw(11)) dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
        .p_base(p_base), .num_x(num_x), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // Expected per-cycle trace for one pass; cycle 1 is the first cycle after start is sampled.
    logic [33:0] e_inst [0:MAXC-1];
    bit          e_busy [0:MAXC-1];
    bit          e_done [0:MAXC-1];
    bit          vtr    [0:MAXC-1];
    int          last;

    typedef struct {
        logic [10:0] wb, xb, pb, nx;
        bit          acc;
        int          stall_at;
        int          restart_at;
        int          exp_done;
    } vec_t;

    function automatic logic [33:0] f_xrd(input logic [10:0] a);
        logic [33:0] v;
        v = IDLE; v[19] = 1'b0; v[17:7] = a;
        return v;
    endfunction

    function automatic logic [33:0] f_ord0(input logic [10:0] a, input bit acc);
        logic [33:0] v;
        v = IDLE; v[6] = 1'b1; v[33] = acc;
        if (acc) begin v[32] = 1'b0; v[30:20] = a; end
        return v;
    endfunction

    function automatic logic [33:0] f_ord1(input logic [10:0] a, input bit acc);
        logic [33:0] v;
        v = IDLE; v[33] = acc; v[32] = 1'b0; v[31] = 1'b0; v[30:20] = a;
        return v;
    endfunction

    // Builds the whole expected inst stream as a list of phases, then overlays l0_wr one cycle behind every xmem read.
    task automatic build_model(input logic [10:0] wb, xb, pb, nx, input bit acc);
        int c;
        for (int t = 0; t < MAXC; t++) begin
            e_inst[t] = IDLE; e_busy[t] = 1'b0; e_done[t] = 1'b0;
        end
        if (nx == 0) begin
            last = 1;
            e_done[1] = 1'b1;
            return;
        end
        c = 1;
        for (int k = 0; k < ROW; k++) begin e_inst[c] = f_xrd(11'((int'(wb) + k) % 2048)); c++; end
        for (int k = 0; k < COL; k++) begin e_inst[c] = IDLE | 34'h9; c++; end
        c += GAP;
        for (int k = 0; k < int'(nx); k++) begin e_inst[c] = f_xrd(11'((int'(xb) + k) % 2048)); c++; end
        for (int k = 0; k < int'(nx); k++) begin e_inst[c] = IDLE | 34'hA; c++; end
        // Drain: a read goes out the cycle after ofifo_valid is seen high.
        while (!vtr[c] && c < MAXC - 4) c++;
        c++;
        for (int i = 0; i < int'(nx); i++) begin
            e_inst[c] = f_ord0(11'((int'(pb) + i) % 2048), acc); c++;
            e_inst[c] = f_ord1(11'((int'(pb) + i) % 2048), acc);
            if (i < int'(nx) - 1) begin
                while (!vtr[c] && c < MAXC - 4) c++;
            end
            c++;
        end
        last = c;
        e_done[last] = 1'b1;
        for (int t = 1; t < last; t++) e_busy[t] = 1'b1;
        for (int t = 2; t <= last; t++)
            if (e_inst[t-1][19] == 1'b0 && e_inst[t-1][18] == 1'b1) e_inst[t][2] = 1'b1;
    endtask

    task automatic check_cycle(input int id, input int c);
        checks++;
        if (inst !== e_inst[c] || busy !== e_busy[c] || done !== e_done[c]) begin
            errors++;
            $display("FAIL trace vec %0d cyc %0d: got inst=%h busy=%b done=%b, want inst=%h busy=%b done=%b",
                     id, c, inst, busy, done, e_inst[c], e_busy[c], e_done[c]);
        end
    endtask

    task automatic reset_mid_pass(input int id);
        bit bad;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (inst !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset vec %0d: got inst=%h busy=%b done=%b, want inst=%h busy=0 done=0",
                     id, inst, busy, done, IDLE);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            ofifo_valid = 1'b1;
            if (inst !== IDLE || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_quiet vec %0d: activity after reset, last inst=%h busy=%b done=%b", id, inst, busy, done);
        end
    endtask

    task automatic run_pass(input int id, input logic [10:0] wb, xb, pb, nx, input bit acc,
                            input int restart_at, input int rst_at, input int exp_done);
        int done_cyc;
        done_cyc = -1;
        build_model(wb, xb, pb, nx, acc);
        @(posedge clk); #1;
        start = 1'b1; w_base = wb; x_base = xb; p_base = pb; num_x = nx; acc_en = acc;
        ofifo_valid = vtr[0];
        @(posedge clk);
        for (int c = 1; c <= last + 3; c++) begin
            #1;
            // Scramble the config inputs: the pass must run on the values captured at start.
            start       = (c == restart_at);
            w_base      = 11'($urandom);
            x_base      = 11'($urandom);
            p_base      = 11'($urandom);
            num_x       = 11'($urandom_range(0, 9));
            acc_en      = 1'($urandom);
            ofifo_valid = vtr[c];
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            check_cycle(id, c);
            if (c == rst_at) begin
                reset_mid_pass(id);
                return;
            end
            @(posedge clk);
        end
        start = 1'b0;
        if (exp_done >= 0) begin
            checks++;
            if (done_cyc != exp_done) begin
                errors++;
                $display("FAIL done_cycle vec %0d: got %0d want %0d", id, done_cyc, exp_done);
            end
        end
    endtask

    vec_t vecs [7];

    initial begin
        reset = 1'b0; start = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b0;
        w_base = '0; x_base = '0; p_base = '0; num_x = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (inst !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got inst=%h busy=%b done=%b want inst=%h busy=0 done=0", inst, busy, done, IDLE);
        end
        reset = 1'b1;

        //           wb      xb      pb      nx     acc stall restart done
        vecs[0] = '{11'h010, 11'h100, 11'h020, 11'd4, 0, -1, -1, 50};  // basic pass
        vecs[1] = '{11'h010, 11'h100, 11'h020, 11'd4, 1, -1, -1, 50};  // accumulate
        vecs[2] = '{11'h010, 11'h100, 11'h020, 11'd4, 0, 43, -1, 55};  // OFIFO stall of 5 cycles
        vecs[3] = '{11'h7FE, 11'h100, 11'h020, 11'd4, 0, -1, -1, 50};  // weight address wrap
        vecs[4] = '{11'h010, 11'h100, 11'h020, 11'd0, 0, -1, -1, 1};   // zero count
        vecs[5] = '{11'h010, 11'h100, 11'h020, 11'd4, 0, -1, 12, 50};  // start during WLD
        vecs[6] = '{11'h005, 11'h7FF, 11'h7FE, 11'd4, 1, -1, -1, 50};  // x/p address wrap

        for (int v = 0; v < 7; v++) begin
            for (int t = 0; t < MAXC; t++) vtr[t] = 1'b1;
            if (vecs[v].stall_at >= 0)
                for (int t = 0; t < 5; t++) vtr[vecs[v].stall_at + t] = 1'b0;
            run_pass(v, vecs[v].wb, vecs[v].xb, vecs[v].pb, vecs[v].nx, vecs[v].acc,
                     vecs[v].restart_at, -1, vecs[v].exp_done);
        end

        // Reset asserted in the middle of XEX.
        for (int t = 0; t < MAXC; t++) vtr[t] = 1'b1;
        run_pass(100, 11'h010, 11'h100, 11'h020, 11'd4, 1'b0, -1, 38, -1);

        // Randomised passes with a random ofifo_valid pattern.
        for (int r = 0; r < 20; r++) begin
            for (int t = 0; t < MAXC; t++) vtr[t] = (t >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
            run_pass(200 + r, 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(0, 6)),
                     1'($urandom), -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
